alu_word_sequencer: RTL
=======================

// Module: alu_word_sequencer
// PURPOSE
//  Multi-cycle controller that runs wide (W*WORDS-bit) operations on the single W-bit alu.
//  - Accepts one command per valid/ready handshake and drives the alu one word per cycle, LSW first.
//  - Chains carry between words and accumulates result plus flags.
//  - Sits between the command source and the alu; it owns every alu input port.
// PARAMETERS
//  W      4  alu word width (matches alu #(W))
//  WORDS  4  words per operand; operand width N = W*WORDS; WORDS >= 1
// PORTS
//  clk           in   1    clock, all state on rising edge
//  rst           in   1    synchronous reset, active-high
//  cmd_valid     in   1    command present
//  cmd_ready     out  1    sequencer can accept a command
//  cmd_opcode    in   W    alu opcode (0-3 shifts, 4 not, 5 and, 6 or, 7 xor, 8 add, 9 sub)
//  cmd_a         in   N    operand a
//  cmd_b         in   N    operand b
//  cmd_carry_in  in   1    carry into word 0 (add/sub only)
//  alu_opcode    out  W    to alu.opcode
//  alu_a         out  W    to alu.a, current word of a
//  alu_b         out  W    to alu.b, current word of b
//  alu_carry_in  out  1    to alu.carry_in
//  alu_result    in   W    from alu._output
//  alu_carry_out in   1    from alu.carry_out
//  alu_overflow  in   1    from alu.overflow
//  res_valid     out  1    result available
//  res_ready     in   1    consumer takes result
//  res_data      out  N    wide result
//  res_carry     out  1    carry out of MSW (add/sub), else 0
//  res_overflow  out  1    signed overflow of MSW (add/sub), else 0
//  res_negative  out  1    res_data[N-1]
//  res_zero      out  1    res_data == 0
//  res_error     out  1    opcode unsupported (0-3, >9); res_data = 0, all other flags 0
// BEHAVIOUR
//  - States: IDLE -> RUN -> DONE -> IDLE.
//  - Reset: state IDLE; cmd_ready=1; res_valid=0; res_* all 0; alu_* outputs 0; word index 0.
//  - IDLE
//    - cmd_ready=1.
//    - On cmd_valid: latch opcode, a, b, carry_in; clear accumulator and zero-tracker.
//    - Supported opcode: -> RUN, idx=0. Unsupported: -> DONE with res_error=1.
//  - RUN
//    - cmd_ready=0. alu_opcode = latched opcode; alu_a/alu_b = word idx of latched a/b.
//    - alu_carry_in: idx 0 = latched carry_in (add/sub) or 0; idx>0 = registered carry from word idx-1.
//    - Each cycle: store alu_result into word idx, register alu_carry_out, AND word-zero into tracker.
//    - When idx = WORDS-1: capture carry/overflow from that cycle, -> DONE; else idx+1.
//  - DONE
//    - res_valid=1; res_* held stable until the cycle res_ready=1, then -> IDLE.
//    - No command is accepted in the handoff cycle; next acceptance is the following cycle.
//  - Latency: accept at edge k, res_valid high from edge k+WORDS (unsupported: k+1).
//    Best throughput: one command per WORDS+2 cycles.
//  - Sub convention: alu computes a + ~b + carry_in (carry=1 means no borrow); chain unchanged.
//  - Logic ops (not/and/or/xor): carries forced 0; res_carry = res_overflow = 0.
//  - Not ignores b.
//  - WORDS=1: RUN lasts exactly one cycle.
//  - idx never exceeds WORDS-1; no wrap.
//  - Mid-operation rst discards the command and restores reset values the next cycle.
//  - cmd_* changes while not accepted are ignored.
// TESTING (W=4, WORDS=4, N=16)
//  - add 0x00FF+0x0001 cin0 -> res 0x0100, carry0 ovf0 neg0 zero0, res_valid 4 cycles after accept.
//  - add 0xFFFF+0x0001 cin0 -> res 0x0000, carry1 zero1; add 0x7FFF+0x0001 -> 0x8000, ovf1 neg1.
//  - sub 0x1000-0x0001 cin1 -> res 0x0FFF, carry1; sub 0x0000-0x0001 cin1 -> 0xFFFF, carry0 neg1.
//  - xor 0xA5A5^0xA5A5 -> 0x0000, zero1, carry0; opcode 2 -> res_error1, data 0, valid after 1 cycle.
//  - res_ready low 5 cycles in DONE -> res_valid/res_* stable, cmd_ready 0; cmd_valid ignored.
//  - rst high during RUN idx 2 -> next cycle IDLE, cmd_ready1, res_valid0, res_* 0.
//    A following add completes correctly.

Source files
------------

// File: rtl/alu_word_sequencer_if.sv
// alu_word_sequencer_if: command, result and alu-side signals of the word sequencer
interface alu_word_sequencer_if #(parameter int W = 4, parameter int WORDS = 4);
    localparam int N = W * WORDS;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [W-1:0] cmd_opcode;
    logic [N-1:0] cmd_a;
    logic [N-1:0] cmd_b;
    logic         cmd_carry_in;
    logic [W-1:0] alu_opcode;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic         alu_carry_in;
    logic [W-1:0] alu_result;
    logic         alu_carry_out;
    logic         alu_overflow;
    logic         res_valid;
    logic         res_ready;
    logic [N-1:0] res_data;
    logic         res_carry;
    logic         res_overflow;
    logic         res_negative;
    logic         res_zero;
    logic         res_error;
    modport master (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_carry_in, res_ready,
               alu_result, alu_carry_out, alu_overflow,
        input  cmd_ready, alu_opcode, alu_a, alu_b, alu_carry_in,
               res_valid, res_data, res_carry, res_overflow, res_negative, res_zero, res_error
    );
    modport slave (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_carry_in, res_ready,
               alu_result, alu_carry_out, alu_overflow,
        output cmd_ready, alu_opcode, alu_a, alu_b, alu_carry_in,
               res_valid, res_data, res_carry, res_overflow, res_negative, res_zero, res_error
    );
endinterface

// File: rtl/alu_word_sequencer.sv
// alu_word_sequencer: runs W*WORDS-bit operations on a W-bit alu, one word per cycle, LSW first
module alu_word_sequencer #(parameter int W = 4, parameter int WORDS = 4) (
    input logic clk,
    input logic rst,
    alu_word_sequencer_if.slave bus
);
    localparam int N = W * WORDS;
    localparam int IW = WORDS > 1 ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);
    localparam logic [W-1:0] OP_NOT = W'(4);
    localparam logic [W-1:0] OP_ADD = W'(8);
    localparam logic [W-1:0] OP_SUB = W'(9);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_nx;
    logic [W-1:0] op;
    logic [N-1:0] a, b, acc;
    logic [IW-1:0] idx;
    logic cin, carry, zero, res_c, res_o, err;
    logic arith, supported, accept, run, done;

    assign arith = op == OP_ADD || op == OP_SUB;
    assign supported = bus.cmd_opcode >= OP_NOT && bus.cmd_opcode <= OP_SUB;
    assign accept = state == IDLE && bus.cmd_valid;
    assign run = state == RUN;
    assign done = state == DONE;

    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;

    always_comb begin
        state_nx = state;
        if (accept) state_nx = supported ? RUN : DONE;
        else if (run && idx == LAST) state_nx = DONE;
        else if (done && bus.res_ready) state_nx = IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op <= '0;
            a <= '0;
            b <= '0;
            acc <= '0;
            idx <= '0;
            cin <= 1'b0;
            carry <= 1'b0;
            zero <= 1'b0;
            res_c <= 1'b0;
            res_o <= 1'b0;
            err <= 1'b0;
        end else if (accept) begin
            op <= bus.cmd_opcode;
            a <= bus.cmd_a;
            b <= bus.cmd_b;
            cin <= bus.cmd_carry_in;
            acc <= '0;
            idx <= '0;
            carry <= 1'b0;
            zero <= supported;
            res_c <= 1'b0;
            res_o <= 1'b0;
            err <= !supported;
        end else if (run) begin
            acc[idx*W +: W] <= bus.alu_result;
            carry <= arith & bus.alu_carry_out;
            zero <= zero & (bus.alu_result == '0);
            if (idx == LAST) begin
                res_c <= arith & bus.alu_carry_out;
                res_o <= arith & bus.alu_overflow;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

    // alu inputs are idle-zero; word 0 takes the command carry only for add/sub
    always_comb begin
        bus.alu_opcode = run ? op : '0;
        bus.alu_a = run ? a[idx*W +: W] : '0;
        bus.alu_b = run ? b[idx*W +: W] : '0;
        bus.alu_carry_in = run && (idx == '0 ? arith & cin : carry);
    end

    assign bus.cmd_ready = state == IDLE;
    assign bus.res_valid = done;
    assign bus.res_data = done ? acc : '0;
    assign bus.res_carry = done & res_c;
    assign bus.res_overflow = done & res_o;
    assign bus.res_negative = done & acc[N-1];
    assign bus.res_zero = done & zero;
    assign bus.res_error = done & err;
endmodule
